// File: rtl/id_exe_skid_reg_if.sv
// ID->EXE handshake bundle: decode-side input channel and execute-side output channel.
// master = decode/execute environment, slave = the boundary register.
interface id_exe_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_wb_en;
  logic [RD_W-1:0]   in_rd_addr;
  logic [DATA_W-1:0] in_imm;
  logic              out_valid;
  logic              out_ready;
  logic              out_wb_en;
  logic [RD_W-1:0]   out_rd_addr;
  logic [DATA_W-1:0] out_imm;

  modport master (
    output in_valid, in_wb_en, in_rd_addr, in_imm, out_ready,
    input  in_ready, out_valid, out_wb_en, out_rd_addr, out_imm
  );

  modport slave (
    input  in_valid, in_wb_en, in_rd_addr, in_imm, out_ready,
    output in_ready, out_valid, out_wb_en, out_rd_addr, out_imm
  );
endinterface

// File: rtl/id_exe_skid_reg.sv
// ID->EXE boundary register with 2-entry skid buffer, flush and
// saturating stall-cycle counter.
module id_exe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  id_exe_skid_reg_if.slave bus
);

  typedef struct packed {
    logic              wb_en;
    logic [RD_W-1:0]   rd_addr;
    logic [DATA_W-1:0] imm;
  } pay_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  pay_t             m_q, m_d;
  pay_t             s_q, s_d;
  pay_t             in_pay;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m_vld;
  logic             accept;
  logic             issue;

  assign in_pay = '{
    wb_en:   bus.in_wb_en,
    rd_addr: bus.in_rd_addr,
    imm:     bus.in_imm
  };

  // in_ready comes only from registered state, never from out_ready
  assign m_vld        = (state_q != EMPTY);
  assign bus.in_ready = (state_q != FULL) & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;
  assign issue        = m_vld & bus.out_ready;

  assign bus.out_valid   = m_vld;
  assign bus.out_wb_en   = m_q.wb_en & m_vld;
  assign bus.out_rd_addr = m_q.rd_addr;
  assign bus.out_imm     = m_q.imm;
  assign stall_cnt       = cnt_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          m_d     = in_pay;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && issue) begin
          m_d = in_pay;
        end else if (accept) begin
          s_d     = in_pay;
          state_d = FULL;
        end else if (issue) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (issue) begin
          m_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // a concurrent accept is dropped; the issue already happened on EXE side
    if (flush) begin
      state_d = EMPTY;
      m_d     = '0;
      s_d     = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (m_vld && !bus.out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_id_exe_skid_reg.sv
// Bench for id_exe_skid_reg: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_id_exe_skid_reg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct {
    bit          wb;
    bit [4:0]    rd;
    bit [31:0]   imm;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             clr_cnt;
  logic [CNT_W-1:0] stall_cnt;

  id_exe_skid_reg_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

  id_exe_skid_reg #(
    .DATA_W(DATA_W),
    .RD_W  (RD_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .clr_cnt  (clr_cnt),
    .stall_cnt(stall_cnt),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: in-flight FIFO, last visible payload, stall count
  ent_t q[$];
  ent_t shown;
  int   cnt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, bit wb, bit [4:0] rd, bit [31:0] imm,
                       bit ordy, bit fl, bit clr, bit r);
    bus.in_valid   = v;
    bus.in_wb_en   = wb;
    bus.in_rd_addr = rd;
    bus.in_imm     = imm;
    bus.out_ready  = ordy;
    flush          = fl;
    clr_cnt        = clr;
    rst            = r;
  endtask

  task automatic cycle();
    bit   rdy, vld, acc, iss;
    ent_t e;
    #2;
    rdy = (q.size() < 2) && !rst;
    vld = (q.size() > 0);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(vld));
    chk("out_wb_en", 32'(bus.out_wb_en), 32'(vld ? q[0].wb : 1'b0));
    chk("out_rd_addr", 32'(bus.out_rd_addr), 32'(shown.rd));
    chk("out_imm", bus.out_imm, shown.imm);
    chk("stall_cnt", 32'(stall_cnt), 32'(cnt));
    acc   = bus.in_valid && rdy;
    iss   = vld && bus.out_ready;
    e.wb  = bus.in_wb_en;
    e.rd  = bus.in_rd_addr;
    e.imm = bus.in_imm;
    @(posedge clk);
    if (rst) begin
      q.delete();
      shown = '{0, 0, 0};
      cnt   = 0;
    end else begin
      if (clr_cnt) cnt = 0;
      else if (vld && !bus.out_ready && cnt < CMAX) cnt++;
      if (flush) begin
        q.delete();
        shown = '{0, 0, 0};
      end else begin
        if (iss) void'(q.pop_front());
        if (acc) q.push_back(e);
        if (q.size() > 0) shown = q[0];
      end
    end
    #1;
  endtask

  initial begin
    shown = '{0, 0, 0};
    cnt   = 0;
    drive(1, 1, 5'd7, 32'hDEAD, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    q.delete();
    // reset held 2 cycles with in_valid high
    repeat (2) cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    cycle();
    // streaming
    drive(1, 1, 5'd1, 32'h11, 1, 0, 0, 0); cycle();
    drive(1, 1, 5'd2, 32'h22, 1, 0, 0, 0); cycle();
    drive(1, 1, 5'd3, 32'h33, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 0); repeat (2) cycle();
    // back-pressure into skid
    drive(1, 1, 5'd10, 32'hA, 0, 0, 0, 0); cycle();
    drive(1, 0, 5'd11, 32'hB, 0, 0, 0, 0); cycle();
    drive(1, 1, 5'd12, 32'hF, 0, 0, 0, 0); repeat (3) cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 0); repeat (3) cycle();
    // flush from FULL with concurrent input C
    drive(1, 1, 5'd10, 32'hA, 0, 0, 0, 0); cycle();
    drive(1, 1, 5'd11, 32'hB, 0, 0, 0, 0); cycle();
    drive(1, 1, 5'd12, 32'hC, 0, 1, 0, 0); cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 0); repeat (2) cycle();
    // counter saturation, clear, clear during stall
    drive(1, 1, 5'd4, 32'h44, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0); repeat (20) cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0); repeat (2) cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 0); cycle();
    // reset mid-operation while FULL
    drive(1, 1, 5'd11, 32'hB, 0, 0, 0, 0); cycle();
    drive(1, 1, 5'd12, 32'hC, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 0); repeat (3) cycle();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 7), 1'($urandom), 5'($urandom),
            $urandom, ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 49) == 0));
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
